// File: rtl/ram_nr2w_lvt.sv
// rtl/ram_nr2w_lvt.sv - 2-write N-read RAM built from replicated 1R1W banks steered by a live value table
module ram_nr2w_lvt #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int NR     = 4,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    w_addr_1,
    input  logic [DATA_W-1:0]    w_din_1,
    input  logic                 w_enb_1,
    input  logic [ADDR_W-1:0]    w_addr_2,
    input  logic [DATA_W-1:0]    w_din_2,
    input  logic                 w_enb_2,
    input  logic [NR*ADDR_W-1:0] r_addr,
    output logic [NR*DATA_W-1:0] r_dout,
    output logic                 ready,
    output logic                 w_conflict
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic              init_last;
    logic              wr_1;
    logic              wr_2;
    logic              same_addr;
    logic [DEPTH-1:0]  lvt;

    assign init_last = (init_cnt == {ADDR_W{1'b1}});
    assign wr_1      = ready & w_enb_1;
    assign wr_2      = ready & w_enb_2;
    assign same_addr = (w_addr_1 == w_addr_2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            INIT: begin
                if (init_last) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_conflict <= 1'b0;
        end else begin
            w_conflict <= wr_1 & wr_2 & same_addr;
        end
    end

    // Port 2 is assigned last so it owns the entry when both ports hit one address.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            lvt[init_cnt] <= 1'b0;
        end else begin
            if (wr_1) begin
                lvt[w_addr_1] <= 1'b0;
            end
            if (wr_2) begin
                lvt[w_addr_2] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_port
        logic [DATA_W-1:0] bank_1 [DEPTH];
        logic [DATA_W-1:0] bank_2 [DEPTH];
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] dout_q;

        assign ra = r_addr[k*ADDR_W +: ADDR_W];

        always_ff @(posedge clk) begin
            if (wr_1) begin
                bank_1[w_addr_1] <= w_din_1;
            end
            if (wr_2) begin
                bank_2[w_addr_2] <= w_din_2;
            end
        end

        // Array reads see pre-edge contents, so the read-old mode needs no extra logic.
        always_comb begin
            rd = lvt[ra] ? bank_2[ra] : bank_1[ra];
            if (BYPASS != 0) begin
                if (wr_2 && (w_addr_2 == ra)) begin
                    rd = w_din_2;
                end else if (wr_1 && (w_addr_1 == ra)) begin
                    rd = w_din_1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
            end else if (!ready) begin
                dout_q <= '0;
            end else begin
                dout_q <= rd;
            end
        end

        assign r_dout[k*DATA_W +: DATA_W] = dout_q;
    end

endmodule

// File: tb/tb_ram_nr2w_lvt.sv
// tb/tb_ram_nr2w_lvt.sv - self-checking bench for ram_nr2w_lvt against a flat-memory reference model
module tb_ram_nr2w_lvt;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NR     = 4;
    localparam int DEPTH  = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [ADDR_W-1:0]    w_addr_1 = '0;
    logic [DATA_W-1:0]    w_din_1 = '0;
    logic                 w_enb_1 = 1'b0;
    logic [ADDR_W-1:0]    w_addr_2 = '0;
    logic [DATA_W-1:0]    w_din_2 = '0;
    logic                 w_enb_2 = 1'b0;
    logic [NR*ADDR_W-1:0] r_addr = '0;
    logic [NR*DATA_W-1:0] dout_b;
    logic [NR*DATA_W-1:0] dout_r;
    logic                 ready_b;
    logic                 ready_r;
    logic                 conf_b;
    logic                 conf_r;

    always #5 clk = ~clk;

    ram_nr2w_lvt #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst),
        .w_addr_1(w_addr_1), .w_din_1(w_din_1), .w_enb_1(w_enb_1),
        .w_addr_2(w_addr_2), .w_din_2(w_din_2), .w_enb_2(w_enb_2),
        .r_addr(r_addr), .r_dout(dout_b), .ready(ready_b), .w_conflict(conf_b)
    );

    ram_nr2w_lvt #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .BYPASS(0)) u_dut_ro (
        .clk(clk), .rst(rst),
        .w_addr_1(w_addr_1), .w_din_1(w_din_1), .w_enb_1(w_enb_1),
        .w_addr_2(w_addr_2), .w_din_2(w_din_2), .w_enb_2(w_enb_2),
        .r_addr(r_addr), .r_dout(dout_r), .ready(ready_r), .w_conflict(conf_r)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: one flat memory, a ready countdown, writes applied port 1 then port 2.
    logic [DATA_W-1:0] mem [DEPTH];
    bit                mem_ok [DEPTH];
    bit                m_live = 1'b0;
    bit                m_ready;
    int                m_left;
    logic [DATA_W-1:0] e_b [NR];
    logic [DATA_W-1:0] e_r [NR];
    bit                k_b [NR];
    bit                k_r [NR];
    bit                e_conf;

    function automatic logic [ADDR_W-1:0] ra(input int k);
        return r_addr[k*ADDR_W +: ADDR_W];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_live  <= 1'b1;
            m_ready <= 1'b0;
            m_left  <= DEPTH;
            e_conf  <= 1'b0;
            for (int k = 0; k < NR; k++) begin
                e_b[k] <= '0; e_r[k] <= '0; k_b[k] <= 1'b1; k_r[k] <= 1'b1;
            end
            for (int a = 0; a < DEPTH; a++) mem_ok[a] <= 1'b0;
        end else if (!m_ready) begin
            e_conf <= 1'b0;
            for (int k = 0; k < NR; k++) begin
                e_b[k] <= '0; e_r[k] <= '0; k_b[k] <= 1'b1; k_r[k] <= 1'b1;
            end
            m_left <= m_left - 1;
            if (m_left == 1) m_ready <= 1'b1;
        end else begin
            e_conf <= w_enb_1 && w_enb_2 && (w_addr_1 == w_addr_2);
            for (int k = 0; k < NR; k++) begin
                e_r[k] <= mem[ra(k)];
                k_r[k] <= mem_ok[ra(k)];
                if (w_enb_2 && w_addr_2 == ra(k)) begin
                    e_b[k] <= w_din_2; k_b[k] <= 1'b1;
                end else if (w_enb_1 && w_addr_1 == ra(k)) begin
                    e_b[k] <= w_din_1; k_b[k] <= 1'b1;
                end else begin
                    e_b[k] <= mem[ra(k)]; k_b[k] <= mem_ok[ra(k)];
                end
            end
            if (w_enb_1) begin
                mem[w_addr_1] <= w_din_1; mem_ok[w_addr_1] <= 1'b1;
            end
            if (w_enb_2) begin
                mem[w_addr_2] <= w_din_2; mem_ok[w_addr_2] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("ready_wf", {63'd0, ready_b}, {63'd0, m_ready});
            check("ready_ro", {63'd0, ready_r}, {63'd0, m_ready});
            check("conflict_wf", {63'd0, conf_b}, {63'd0, e_conf});
            check("conflict_ro", {63'd0, conf_r}, {63'd0, e_conf});
            for (int k = 0; k < NR; k++) begin
                if (k_b[k]) check($sformatf("model_dout_wf%0d", k), {32'd0, dout_b[k*DATA_W +: DATA_W]}, {32'd0, e_b[k]});
                if (k_r[k]) check($sformatf("model_dout_ro%0d", k), {32'd0, dout_r[k*DATA_W +: DATA_W]}, {32'd0, e_r[k]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit e1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      input bit e2, input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2);
        w_enb_1 = e1; w_addr_1 = a1; w_din_1 = d1;
        w_enb_2 = e2; w_addr_2 = a2; w_din_2 = d2;
    endtask

    task automatic idle();
        w_enb_1 = 1'b0;
        w_enb_2 = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      input logic [ADDR_W-1:0] a2, input logic [ADDR_W-1:0] a3);
        r_addr = {a3, a2, a1, a0};
    endtask

    task automatic chk_port(input string name, input int k, input logic [DATA_W-1:0] eb, input logic [DATA_W-1:0] er);
        check($sformatf("%s_wf%0d", name, k), {32'd0, dout_b[k*DATA_W +: DATA_W]}, {32'd0, eb});
        check($sformatf("%s_ro%0d", name, k), {32'd0, dout_r[k*DATA_W +: DATA_W]}, {32'd0, er});
    endtask

    task automatic chk_all(input string name, input logic [DATA_W-1:0] eb, input logic [DATA_W-1:0] er);
        for (int k = 0; k < NR; k++) chk_port(name, k, eb, er);
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            tick();
            cycles++;
            if (ready_b) break;
        end
    endtask

    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", {63'd0, ready_b}, 64'd0);
        check("dout_in_reset", {63'd0, |dout_b}, 64'd0);
        rst = 1'b1;
        rd(1, 2, 3, 4);
        wait_ready(n);
        check("init_len", n, 64'd16);

        wr(1'b1, 4'd5, 32'hAAAA0001, 1'b0, 4'd0, 32'h0);
        tick();
        wr(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 32'hBBBB0002);
        tick();
        idle(); rd(5, 5, 5, 5);
        tick();
        chk_all("p2_after_p1", 32'hBBBB0002, 32'hBBBB0002);

        wr(1'b1, 4'd3, 32'h11, 1'b1, 4'd3, 32'h22);
        tick();
        check("conflict_pulse", {63'd0, conf_b}, 64'd1);
        idle(); rd(3, 3, 3, 3);
        tick();
        check("conflict_drop", {63'd0, conf_b}, 64'd0);
        chk_all("conflict_winner", 32'h22, 32'h22);

        wr(1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h202);
        tick();
        check("no_conflict", {63'd0, conf_b}, 64'd0);
        idle(); rd(1, 2, 1, 2);
        tick();
        chk_port("dual_write", 0, 32'h101, 32'h101);
        chk_port("dual_write", 1, 32'h202, 32'h202);

        wr(1'b1, 4'd7, 32'h44, 1'b0, 4'd0, 32'h0);
        tick();
        wr(1'b1, 4'd7, 32'h55, 1'b0, 4'd0, 32'h0); rd(7, 7, 7, 7);
        tick();
        chk_all("rdw_p1", 32'h55, 32'h44);
        wr(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h66);
        tick();
        chk_all("rdw_p2", 32'h66, 32'h55);
        wr(1'b1, 4'd7, 32'h77, 1'b1, 4'd7, 32'h88);
        tick();
        chk_all("rdw_conflict", 32'h88, 32'h66);
        wr(1'b1, 4'd7, 32'h99, 1'b0, 4'd0, 32'h0);
        tick();
        chk_all("rdw_p1_again", 32'h99, 32'h88);
        idle();
        tick();
        chk_all("p1_reclaims", 32'h99, 32'h99);

        wr(1'b1, 4'd8, 32'h808, 1'b1, 4'd9, 32'h909);
        tick();
        wr(1'b1, 4'd10, 32'hA0A, 1'b1, 4'd11, 32'hB0B);
        tick();
        wr(1'b1, 4'd9, 32'h999, 1'b1, 4'd10, 32'hAAA); rd(8, 9, 10, 11);
        tick();
        chk_port("distinct", 0, 32'h808, 32'h808);
        chk_port("distinct", 1, 32'h999, 32'h909);
        chk_port("distinct", 2, 32'hAAA, 32'hA0A);
        chk_port("distinct", 3, 32'hB0B, 32'hB0B);
        idle();
        tick();
        chk_port("distinct_next", 1, 32'h999, 32'h999);
        chk_port("distinct_next", 2, 32'hAAA, 32'hAAA);

        for (int i = 0; i < 60; i++) begin
            wr((i % 3) != 0, ADDR_W'((i * 5) % 16), 32'h1000_0000 + i,
               (i % 4) != 1, ADDR_W'((i * 3) % 16), 32'h2000_0000 + i * 3);
            rd(ADDR_W'(i % 16), ADDR_W'((i + 3) % 16), ADDR_W'((i * 5) % 16), ADDR_W'((i * 3) % 16));
            tick();
        end
        idle();
        tick();

        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("ready_drop", {63'd0, ready_b}, 64'd0);
        check("dout_async_clear", {63'd0, |dout_b}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr(1'b1, 4'd4, 32'hBAD, 1'b1, 4'd4, 32'hBAD);
        rd(4, 4, 4, 4);
        wait_ready(n);
        idle();
        check("reinit_len", n, 64'd16);
        tick();
        check("init_write_ignored", {63'd0, dout_b[31:0] != 32'hBAD}, 64'd1);
        wr(1'b1, 4'd4, 32'h1234, 1'b0, 4'd0, 32'h0);
        tick();
        idle();
        tick();
        chk_all("after_reinit", 32'h1234, 32'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
